// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI master: FSM states, mode constant, defaults.
package spi_master_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_DONE,
    ST_GAP
  } spi_state_t;

  // {CPOL, CPHA}; only mode 0 is implemented.
  localparam logic [1:0] SPI_MODE0      = 2'b00;
  localparam logic       SCLK_IDLE      = SPI_MODE0[1];
  localparam int         DEFAULT_DATA_W = 8;

endpackage

// File: rtl/spi_master_ctrl_clk_div.sv
// SCLK generator: half-period counter plus sclk toggle, active only while enabled.
module spi_clk_div
  import spi_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_en,
  output logic fall_en
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV);
  localparam logic [CW-1:0] LAST   = CW'(1);

  logic [CW-1:0] hcnt;
  logic          boundary;

  assign boundary = en && (hcnt == LAST);
  assign rise_en  = boundary && !sclk;
  assign fall_en  = boundary && sclk;

  // Counts down to 1 and reloads; held at the reload value while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= RELOAD;
      sclk <= SCLK_IDLE;
    end else if (!en) begin
      hcnt <= RELOAD;
      sclk <= SCLK_IDLE;
    end else if (boundary) begin
      hcnt <= RELOAD;
      sclk <= ~sclk;
    end else begin
      hcnt <= hcnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: one DATA_W-bit word per start, MSB first, start/busy/valid host handshake.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int CLK_DIV = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(2 * DATA_W + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_HALF = BW'(2 * DATA_W - 1);

  spi_state_t        state;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [CW-1:0]     wait_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              xfer_en;
  logic              rise_en;
  logic              fall_en;
  logic              wait_done;

  assign xfer_en   = (state == ST_XFER);
  assign wait_done = (wait_cnt == WAIT_LAST);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk     (i_clk),
    .rst     (i_reset),
    .en      (xfer_en),
    .sclk    (sclk),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      tx_sr      <= '0;
      rx_sr      <= '0;
      wait_cnt   <= '0;
      bit_cnt    <= '0;
      cs         <= 1'b1;
      mosi       <= 1'b0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            // tx_sr holds the bits still to be sent, pre-aligned to the MSB.
            tx_sr    <= {i_tx_data[DATA_W-2:0], 1'b0};
            mosi     <= i_tx_data[DATA_W-1];
            cs       <= 1'b0;
            o_busy   <= 1'b1;
            wait_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (wait_done) begin
            wait_cnt <= '0;
            state    <= ST_XFER;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_XFER: begin
          if (rise_en || fall_en) bit_cnt <= bit_cnt + 1'b1;
          if (rise_en) rx_sr <= {rx_sr[DATA_W-2:0], miso};
          if (fall_en) begin
            if (bit_cnt == LAST_HALF) begin
              state <= ST_HOLD;
            end else begin
              mosi  <= tx_sr[DATA_W-1];
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
          end
        end
        ST_HOLD: begin
          if (wait_done) begin
            wait_cnt <= '0;
            cs       <= 1'b1;
            mosi     <= 1'b0;
            state    <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          o_rx_data  <= rx_sr;
          o_rx_valid <= 1'b1;
          state      <= ST_GAP;
        end
        ST_GAP: begin
          if (wait_done) begin
            wait_cnt <= '0;
            o_busy   <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
